// File: rtl/sram_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the arbiter and the unified SRAM.
// The slave modport is the arbiter's view. The master modport is the
// requesters' view, together with the SRAM read-data return path.
interface sram_arbiter_if;
    // fetch stage
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    // memory stage
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_mode;
    logic        mem_us;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    // sram port
    logic        sram_en;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [2:0]  sram_mode;
    logic        sram_us;
    logic [31:0] sram_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_ready, if_rvalid, if_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mode, mem_us,
        output mem_ready, mem_rvalid, mem_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata, sram_mode, sram_us,
        input  sram_rdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_ready, if_rvalid, if_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mode, mem_us,
        input  mem_ready, mem_rvalid, mem_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata, sram_mode, sram_us,
        output sram_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter for the fetch and memory stages.
// Data accesses have priority. A starvation counter guarantees fetch a grant
// after STARVE_MAX contended data grants. Each 1-cycle read response is routed
// back to the requester that was granted in the previous cycle.
module sram_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic          clk,
    input logic          reset,
    sram_arbiter_if.slave bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MODE_W = 3;

    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [MODE_W-1:0] MODE_WORD  = MODE_W'(3'b010);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_MEM  = 2'd2
    } grant_t;

    grant_t             grant;
    logic               if_elig;
    logic [CNT_W-1:0]   starve_cnt;
    logic [CNT_W-1:0]   starve_cnt_next;
    logic               resp_if;
    logic               resp_if_next;
    logic               resp_mem;
    logic               resp_mem_next;

    // State: starvation counter and in-flight read ownership
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            resp_if    <= 1'b0;
            resp_mem   <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_next;
            resp_if    <= resp_if_next;
            resp_mem   <= resp_mem_next;
        end
    end

    // Grant decision and next-state for the counter and response trackers
    always_comb begin
        grant           = GNT_NONE;
        starve_cnt_next = '0;
        resp_if_next    = 1'b0;
        resp_mem_next   = 1'b0;
        if_elig         = bus.if_req && !bus.if_flush;

        if (bus.mem_req && (!if_elig || (starve_cnt != STARVE_LIM))) begin
            grant = GNT_MEM;
        end else if (if_elig) begin
            grant = GNT_IF;
        end

        // Count only data grants that made an eligible fetch wait
        if ((grant == GNT_MEM) && if_elig) begin
            starve_cnt_next = (starve_cnt == STARVE_LIM) ? STARVE_LIM
                                                         : starve_cnt + CNT_W'(1);
        end

        resp_if_next  = (grant == GNT_IF);
        resp_mem_next = (grant == GNT_MEM) && !bus.mem_we;
    end

    // SRAM command and ready handshakes for the granted requester
    always_comb begin
        bus.if_ready   = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.sram_en    = 1'b0;
        bus.sram_we    = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        bus.sram_mode  = '0;
        bus.sram_us    = 1'b0;

        unique case (grant)
            GNT_IF: begin
                bus.if_ready  = 1'b1;
                bus.sram_en   = 1'b1;
                bus.sram_addr = bus.if_addr;
                bus.sram_mode = MODE_WORD;
            end
            GNT_MEM: begin
                bus.mem_ready  = 1'b1;
                bus.sram_en    = 1'b1;
                bus.sram_we    = bus.mem_we;
                bus.sram_addr  = bus.mem_addr;
                bus.sram_wdata = bus.mem_wdata;
                bus.sram_mode  = bus.mem_mode;
                bus.sram_us    = bus.mem_us;
            end
            default: begin
            end
        endcase
    end

    // Response routing; a flush kills a fetch response arriving this cycle
    always_comb begin
        bus.if_rvalid  = resp_if && !bus.if_flush;
        bus.mem_rvalid = resp_mem;
        bus.if_rdata   = bus.if_rvalid  ? bus.sram_rdata : DATA_W'(0);
        bus.mem_rdata  = bus.mem_rvalid ? bus.sram_rdata : DATA_W'(0);
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, grant model and response scoreboard.
module tb_sram_arbiter;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned WORDS      = 1024;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
    } resp_t;

    logic clk;
    logic reset;
    sram_arbiter_if bus ();

    sram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] sram_mem [0:WORDS-1];
    logic [31:0] ref_mem  [0:WORDS-1];
    resp_t       sb_q [$];
    int unsigned m_starve;
    logic [2:0]  drv_mode;
    logic        drv_us;
    int          total;
    int          bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM with 1-cycle read latency
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) sram_mem[bus.sram_addr[11:2]] <= bus.sram_wdata;
            else             bus.sram_rdata <= sram_mem[bus.sram_addr[11:2]];
        end
    end

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, check responses and grant at negedge, update models
    task automatic step(input logic ireq, input logic [31:0] iaddr, input logic iflush,
                        input logic mreq, input logic mwe, input logic [31:0] maddr,
                        input logic [31:0] mwdata, input string tag);
        resp_t       e;
        logic        ev_if, ev_mem, elig, gm, gi;
        logic [31:0] ed;
        bus.if_req    = ireq;
        bus.if_addr   = iaddr;
        bus.if_flush  = iflush;
        bus.mem_req   = mreq;
        bus.mem_we    = mwe;
        bus.mem_addr  = maddr;
        bus.mem_wdata = mwdata;
        bus.mem_mode  = drv_mode;
        bus.mem_us    = drv_us;
        @(negedge clk);

        ev_if = 1'b0; ev_mem = 1'b0; ed = '0;
        if (sb_q.size() > 0) begin
            e      = sb_q.pop_front();
            ev_if  = e.is_if && !iflush;
            ev_mem = !e.is_if;
            ed     = e.data;
        end
        check({tag, " if_rvalid"},  32'(bus.if_rvalid),  32'(ev_if));
        check({tag, " mem_rvalid"}, 32'(bus.mem_rvalid), 32'(ev_mem));
        check({tag, " if_rdata"},   bus.if_rdata,  ev_if  ? ed : 32'h0);
        check({tag, " mem_rdata"},  bus.mem_rdata, ev_mem ? ed : 32'h0);

        elig = ireq && !iflush;
        gm   = mreq && (!elig || (m_starve != STARVE_MAX));
        gi   = !gm && elig;
        check({tag, " if_ready"},   32'(bus.if_ready),  32'(gi));
        check({tag, " mem_ready"},  32'(bus.mem_ready), 32'(gm));
        check({tag, " sram_en"},    32'(bus.sram_en),   32'(gi || gm));
        check({tag, " sram_we"},    32'(bus.sram_we),   32'(gm && mwe));
        check({tag, " sram_addr"},  bus.sram_addr,  gm ? maddr : (gi ? iaddr : 32'h0));
        check({tag, " sram_wdata"}, bus.sram_wdata, gm ? mwdata : 32'h0);
        check({tag, " sram_mode"},  32'(bus.sram_mode), gm ? 32'(drv_mode) : (gi ? 32'd2 : 32'd0));
        check({tag, " sram_us"},    32'(bus.sram_us),   32'(gm && drv_us));

        if (gi) sb_q.push_back('{is_if: 1'b1, data: ref_mem[iaddr[11:2]]});
        if (gm && !mwe) sb_q.push_back('{is_if: 1'b0, data: ref_mem[maddr[11:2]]});
        if (gm && mwe) ref_mem[maddr[11:2]] = mwdata;
        m_starve = (gm && elig) ? m_starve + 1 : 0;

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, tag);
    endtask

    initial begin
        total = 0; bad = 0; m_starve = 0;
        drv_mode = 3'b010; drv_us = 1'b0;
        for (int i = 0; i < int'(WORDS); i++) begin
            sram_mem[i] = init_word(i);
            ref_mem[i]  = init_word(i);
        end
        bus.sram_rdata = '0;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0;
        bus.mem_wdata = '0; bus.mem_mode = '0; bus.mem_us = 1'b0;
        reset = 1'b0;

        // Reset state
        #2;
        check("reset if_rvalid",  32'(bus.if_rvalid),  32'h0);
        check("reset mem_rvalid", 32'(bus.mem_rvalid), 32'h0);
        check("reset if_rdata",   bus.if_rdata,  32'h0);
        check("reset mem_rdata",  bus.mem_rdata, 32'h0);
        check("reset sram_en",    32'(bus.sram_en), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        idle("post_reset");

        // Lone fetch, then its response
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "fetch40");
        idle("fetch40_resp");

        // Contention: data wins, fetch follows, responses in order
        step(1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, "both_load100");
        step(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "fetch80_after");
        idle("fetch80_resp");

        // Starvation: four data grants, fetch on fifth, data again on sixth
        for (int i = 0; i < 7; i++)
            step(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'(32'h400 + 4 * i), 32'h0,
                 $sformatf("starve%0d", i + 1));
        idle("starve_drain");

        // Store then load back
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, "store200");
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, "load200");
        idle("load200_resp");

        // Flush kills in-flight fetch response and blocks fetch grant
        step(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "fetch44");
        step(1'b1, 32'h48, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "flush");
        step(1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "fetch48");
        // Flush alongside a data grant: data proceeds
        drv_mode = 3'b001; drv_us = 1'b1;
        step(1'b1, 32'h4C, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0, "flush_with_load");
        idle("flush_with_load_resp");

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            drv_mode = 3'($urandom_range(0, 7));
            drv_us   = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), {20'h0, 10'($urandom_range(0, 1023)), 2'b00},
                 ($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                 {20'h0, 10'($urandom_range(0, 1023)), 2'b00}, $urandom(),
                 $sformatf("rnd%0d", i));
        end
        idle("rnd_drain");

        // Reset during an outstanding load drops the response
        drv_mode = 3'b010; drv_us = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h108, 32'h0, "load_before_reset");
        bus.mem_req = 1'b0;
        check("inflight mem_rvalid", 32'(bus.mem_rvalid), 32'h1);
        #1 reset = 1'b0;
        #1;
        check("rst_mid mem_rvalid", 32'(bus.mem_rvalid), 32'h0);
        check("rst_mid mem_rdata",  bus.mem_rdata, 32'h0);
        check("rst_mid if_rvalid",  32'(bus.if_rvalid), 32'h0);
        sb_q.delete();
        m_starve = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        idle("after_reset1");
        idle("after_reset2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
